operand_fetch: RTL and testbench
================================

# operand_fetch

Read-side client of the 32-entry register file: accepts decoded instructions, drives both register-file read ports, and tracks pending writes with a busy-bit scoreboard. Source operands are forwarded from the writeback bus when needed. Operands, destination and write flag are registered into a single output stage that feeds the execute stage through a valid/ready handshake. The block sits between decode and execute and observes the same writeback bus that drives the register file's write port.

## Interface
- `WIDTH`, default 32: data width of the registers and operands.
- `DEPTH`, default 32: number of architectural registers. Addresses are fixed at 5 bits. x0 reads as zero and is never marked busy.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: a decoded instruction is presented.
- `in_ready` output 1: the instruction is accepted on this cycle when `in_valid && in_ready`.
- `in_rs1`, `in_rs2`, `in_rd` input 5 each: source and destination register addresses.
- `in_use_rs1`, `in_use_rs2`, `in_writes_rd` input 1 each: operand-usage flags.
- `read_addr1`, `read_addr2` output 5 each: drive the register-file read ports. Combinational copies of `in_rs1` and `in_rs2`.
- `read_data1`, `read_data2` input WIDTH each: combinational read data returned by the register file.
- `wb_en` input 1, `wb_addr` input 5, `wb_data` input WIDTH: writeback bus, the same signals that drive the register-file write port.
- `flush` input 1: discard all in-flight state.
- `out_valid` output 1, `out_ready` input 1: handshake to the execute stage.
- `out_rs1_data`, `out_rs2_data` output WIDTH each, `out_rd` output 5, `out_writes_rd` output 1: registered operand bundle.

## Operation
- **Scoreboard:** `busy[31:0]`, with bit 0 hardwired to 0.
  - Set `busy[in_rd]` on accept when `in_writes_rd` and `in_rd != 0`.
  - Clear `busy[wb_addr]` when `wb_en` and `wb_addr != 0`.
  - If the same register is set and cleared in the same cycle, the set wins.
- **Source hazard (per source s):** `in_use_s && rs != 0 && busy[rs] && !fwd_s`.
  - `fwd_s = wb_en && wb_addr == rs`.
- **Destination hazard (WAW):** `in_writes_rd && rd != 0 && busy[rd] && !(wb_en && wb_addr == rd)`.
- `in_ready = !flush && (!out_valid || out_ready) && !hazard`.
- **Operand select per source, in priority order:**
  1. Zero when `rs == 0`.
  2. `wb_data` when `fwd_s`.
  3. Otherwise `read_data_s`.
  - Unused sources still register whatever this selection produces; the execute stage ignores them.
- An instruction whose `in_rd` equals one of its own sources reads the old value. Its own busy bit is set only after the read.
- **Writeback to a non-busy register:** no scoreboard change. The value is still forwarded if it matches a source.
- **Flush:**
  - Clears `busy` and `out_valid`, and blocks accept.
  - Has priority over accept and writeback clears.
- **Output register:**
  - Loads on accept.
  - `out_valid` stays high and all data holds stable while `out_valid && !out_ready`.

## Timing
- Latency: accept in cycle N, `out_valid` in N+1.
- Throughput: one instruction per cycle when there are no hazards and `out_ready` stays high.
- A RAW hazard on a busy register resolves in the cycle the writeback appears (with `BYPASS_EN`).
- **Reset values:**
  - `busy = 0`, `out_valid = 0`, `out_rs1_data = 0`, `out_rs2_data = 0`, `out_rd = 0`, `out_writes_rd = 0`.
  - `in_ready` is 1 the cycle after reset is released, given no hazard.
- Reset asserted mid-stall or mid-handshake drops all state. No partial output survives.

## Configuration
- `OPFETCH_BYPASS_EN` defined: writeback forwarding is enabled as described above. Zero bubble on a RAW hazard resolved by writeback.
- `OPFETCH_BYPASS_EN` undefined:
  - `fwd_s` is forced to 0, and the WAW exemption for a same-cycle writeback is also removed.
  - A dependent instruction accepts the cycle after the writeback, reading the now-written register file.
  - This costs one bubble per resolved RAW hazard.

## Structure
- **Shared package `rv_pkg`:**
  - `REG_ADDR_W = 5`.
  - `typedef logic [4:0] reg_addr_t`.
  - Packed struct `operand_bundle_t` holding rs1_data, rs2_data, rd and writes_rd.
- **Sub-module `reg_scoreboard`:**
  - Contains the busy vector with its set, clear and flush ports.
  - Exposes three combinational lookups: busy bit for rs1, rs2 and rd.

## Test plan
- **Back-to-back independent instructions:** reset; accept `add x1,x2,x3` then `add x4,x5,x6` with `out_ready = 1`. Expect `out_valid` in consecutive cycles, operands equal to the register-file contents, `in_ready` never low.
- **RAW stall with forwarding:** accept a writer of x5, then present a reader of x5 with `in_use_rs1`. Expect `in_ready = 0` until `wb_en = 1, wb_addr = 5, wb_data = 0xDEADBEEF`. That same cycle, expect accept with `out_rs1_data = 0xDEADBEEF` in the next cycle. Without `OPFETCH_BYPASS_EN`, accept happens one cycle later with the same data.
- **x0 rules:** accept with `in_rd = 0, in_writes_rd = 1`, then a reader of x0. Expect no stall and `out_rs1_data = 0`. A writeback of `wb_addr = 0` changes nothing.
- **Backpressure:** hold `out_ready = 0` for 3 cycles with `out_valid = 1`. Expect `in_ready = 0` and the output bundle unchanged. Release: transfer completes and the next instruction is accepted in the same cycle.
- **WAW and same-cycle set/clear:** x7 busy; present a writer of x7 while `wb_addr = 7`. Expect accept and `busy[7]` still 1 afterward.
- **Flush and reset mid-stall:** with x3 busy and a reader stalled, assert `flush`. Expect `busy = 0` and `out_valid = 0` next cycle, and the reader accepted the following cycle. Repeat with `reset`: expect all outputs return to their reset values.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file types for the decode/operand-fetch/execute slice.
// Addresses are fixed at 5 bits; the operand bundle matches the default 32-bit datapath.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        reg_addr_t         rd;
        logic              writes_rd;
    } operand_bundle_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for pending register writes: one set port (accept),
// one clear port (writeback), flush, and three combinational lookups.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [4:0] rd_addr,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Clear is applied before set so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en && clr_addr != '0) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en && set_addr != '0) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign rd_busy  = busy[rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, stalls on scoreboard hazards and
// registers an operand bundle for execute. Define OPFETCH_BYPASS_EN for writeback forwarding.
module operand_fetch
    import rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic             in_writes_rd,
    output logic [4:0]       read_addr1,
    output logic [4:0]       read_addr2,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rs1_data,
    output logic [WIDTH-1:0] out_rs2_data,
    output logic [4:0]       out_rd,
    output logic             out_writes_rd
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; a producer holding valid keeps its payload stable until that edge.

    reg_addr_t        rs1;
    reg_addr_t        rs2;
    reg_addr_t        rd;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rd_busy;
    logic             fwd1;
    logic             fwd2;
    logic             wb_hits_rd;
    logic             hazard1;
    logic             hazard2;
    logic             hazard_waw;
    logic             accept;
    logic [WIDTH-1:0] rs1_sel;
    logic [WIDTH-1:0] rs2_sel;

    assign rs1 = in_rs1;
    assign rs2 = in_rs2;
    assign rd  = in_rd;

    assign read_addr1 = in_rs1;
    assign read_addr2 = in_rs2;

`ifdef OPFETCH_BYPASS_EN
    assign fwd1       = wb_en && (wb_addr == rs1);
    assign fwd2       = wb_en && (wb_addr == rs2);
    assign wb_hits_rd = wb_en && (wb_addr == rd);
`else
    assign fwd1       = 1'b0;
    assign fwd2       = 1'b0;
    assign wb_hits_rd = 1'b0;
`endif

    reg_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .set_en   (accept && in_writes_rd),
        .set_addr (rd),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rd_addr  (rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign hazard1    = in_use_rs1 && (rs1 != '0) && rs1_busy && !fwd1;
    assign hazard2    = in_use_rs2 && (rs2 != '0) && rs2_busy && !fwd2;
    assign hazard_waw = in_writes_rd && (rd != '0) && rd_busy && !wb_hits_rd;

    assign in_ready = !flush && (!out_valid || out_ready) && !hazard1 && !hazard2 && !hazard_waw;
    assign accept   = in_valid && in_ready;

    // x0 beats forwarding, so a writeback to x0 can never leak into an operand.
    always_comb begin
        rs1_sel = read_data1;
        if (rs1 == '0) begin
            rs1_sel = '0;
        end else if (fwd1) begin
            rs1_sel = wb_data;
        end
        rs2_sel = read_data2;
        if (rs2 == '0) begin
            rs2_sel = '0;
        end else if (fwd2) begin
            rs2_sel = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_rs1_data  <= '0;
            out_rs2_data  <= '0;
            out_rd        <= '0;
            out_writes_rd <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_rs1_data  <= rs1_sel;
            out_rs2_data  <= rs2_sel;
            out_rd        <= in_rd;
            out_writes_rd <= in_writes_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Table-driven bench for operand_fetch with a register-file model and an operand-bundle scoreboard.
// Expectations follow OPFETCH_BYPASS_EN when it is defined for the build.
module tb_operand_fetch;
    import rv_pkg::*;

    localparam int W = $bits(operand_bundle_t);

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, wr;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        ordy, fl, rst;
        logic        rdy, ov;
        logic [31:0] e1, e2;
        logic        cz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_writes_rd;
    logic [4:0]  read_addr1, read_addr2;
    logic [31:0] read_data1, read_data2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_writes_rd;

    logic [31:0] regs [32];
    logic [W-1:0] exp_q[$];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch #(.WIDTH(32), .DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_writes_rd(in_writes_rd),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_writes_rd(out_writes_rd)
    );

    function automatic logic [31:0] f(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Register file model: x0 holds a nonzero value so the DUT's zeroing is observable.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= f(i);
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign read_data1 = regs[read_addr1];
    assign read_data2 = regs[read_addr2];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic ordy, input logic fl, input logic rst,
                       input logic rdy, input logic ov, input logic [31:0] e1, input logic [31:0] e2,
                       input logic cz);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2; t.wr = wr;
        t.wbe = wbe; t.wba = wba; t.wbd = wbd; t.ordy = ordy; t.fl = fl; t.rst = rst;
        t.rdy = rdy; t.ov = ov; t.e1 = e1; t.e2 = e2; t.cz = cz;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        in_valid = t.v; in_rs1 = t.rs1; in_rs2 = t.rs2; in_rd = t.rd;
        in_use_rs1 = t.u1; in_use_rs2 = t.u2; in_writes_rd = t.wr;
        wb_en = t.wbe; wb_addr = t.wba; wb_data = t.wbd;
        out_ready = t.ordy; flush = t.fl; reset = t.rst;
    endtask

    function automatic logic [W-1:0] actual_bundle();
        operand_bundle_t b;
        b.rs1_data = out_rs1_data; b.rs2_data = out_rs2_data;
        b.rd = out_rd; b.writes_rd = out_writes_rd;
        return b;
    endfunction

    initial begin
        vec_t t;
        operand_bundle_t b;

        //   v rs1 rs2 rd u1 u2 wr  wbe wba wbd            ordy fl rst rdy ov  e1             e2             cz
        // back-to-back independent instructions
        add(1, 2, 3, 1, 1, 1, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, f(2),          f(3),          0);
        add(1, 5, 6, 4, 1, 1, 1,   0, 0, 32'h0,          1, 0, 0,  1, 1, f(5),          f(6),          0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 1, 32'h1111_1111,  1, 0, 0,  1, 0, 32'h0,         32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 4, 32'h4444_4444,  1, 0, 0,  1, 0, 32'h0,         32'h0,         0);
        // RAW on x5: writer, stalled reader, writeback
        add(1, 1, 4, 5, 0, 0, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h1111_1111, 32'h4444_4444, 0);
        add(1, 5, 0, 8, 1, 0, 1,   0, 0, 32'h0,          1, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 5, 0, 8, 1, 0, 1,   0, 0, 32'h0,          1, 0, 0,  0, 0, 32'h0,         32'h0,         0);
`ifdef OPFETCH_BYPASS_EN
        add(1, 5, 0, 8, 1, 0, 1,   1, 5, 32'hDEAD_BEEF,  1, 0, 0,  1, 0, 32'hDEAD_BEEF, 32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h0,         32'h0,         0);
`else
        add(1, 5, 0, 8, 1, 0, 1,   1, 5, 32'hDEAD_BEEF,  1, 0, 0,  0, 0, 32'h0,         32'h0,         0);
        add(1, 5, 0, 8, 1, 0, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'hDEAD_BEEF, 32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
`endif
        add(0, 0, 0, 0, 0, 0, 0,   1, 8, 32'h8888_8888,  1, 0, 0,  1, 0, 32'h0,         32'h0,         0);
        // x0 rules: write to x0, read of x0 during a writeback to x0
        add(1, 3, 2, 0, 1, 1, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, f(3),          f(2),          0);
        add(1, 0, 0, 9, 1, 1, 0,   1, 0, 32'hFFFF_FFFF,  1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        // backpressure for three cycles
        add(1, 1, 4, 10, 1, 1, 1,  0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h1111_1111, 32'h4444_4444, 0);
        add(1, 2, 3, 11, 1, 1, 1,  0, 0, 32'h0,          0, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 2, 3, 11, 1, 1, 1,  0, 0, 32'h0,          0, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 2, 3, 11, 1, 1, 1,  0, 0, 32'h0,          0, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 2, 3, 11, 1, 1, 1,  0, 0, 32'h0,          1, 0, 0,  1, 1, f(2),          f(3),          0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        // WAW on x7 with a same-cycle writeback of x7
        add(1, 0, 0, 7, 0, 0, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h0,         32'h0,         0);
`ifdef OPFETCH_BYPASS_EN
        add(1, 1, 4, 7, 0, 0, 1,   1, 7, 32'h7777_7777,  1, 0, 0,  1, 1, 32'h1111_1111, 32'h4444_4444, 0);
        add(1, 7, 0, 0, 1, 0, 0,   0, 0, 32'h0,          1, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 7, 0, 0, 1, 0, 0,   0, 0, 32'h0,          1, 0, 0,  0, 0, 32'h0,         32'h0,         0);
`else
        add(1, 1, 4, 7, 0, 0, 1,   1, 7, 32'h7777_7777,  1, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 1, 4, 7, 0, 0, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h1111_1111, 32'h4444_4444, 0);
        add(1, 7, 0, 0, 1, 0, 0,   0, 0, 32'h0,          1, 0, 0,  0, 1, 32'h0,         32'h0,         0);
`endif
        // flush releases the stalled x7 reader
        add(1, 7, 0, 0, 1, 0, 0,   0, 0, 32'h0,          1, 1, 0,  0, 0, 32'h0,         32'h0,         0);
        add(1, 7, 0, 0, 1, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h7777_7777, 32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        // flush mid-stall with x3 busy and output held
        add(1, 2, 1, 3, 1, 1, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, f(2),          32'h1111_1111, 0);
        add(1, 3, 0, 12, 1, 0, 1,  0, 0, 32'h0,          0, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 3, 0, 12, 1, 0, 1,  0, 0, 32'h0,          0, 1, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 3, 0, 12, 1, 0, 1,  0, 0, 32'h0,          1, 0, 0,  1, 0, f(3),          32'h0,         0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);
        // reset mid-stall
        add(1, 0, 0, 3, 0, 0, 1,   0, 0, 32'h0,          1, 0, 0,  1, 0, 32'h0,         32'h0,         0);
        add(1, 3, 0, 12, 1, 0, 1,  0, 0, 32'h0,          0, 0, 0,  0, 1, 32'h0,         32'h0,         0);
        add(1, 3, 0, 12, 1, 0, 1,  0, 0, 32'h0,          0, 0, 1,  0, 1, 32'h0,         32'h0,         0);
        add(1, 3, 0, 12, 1, 0, 1,  0, 0, 32'h0,          1, 0, 0,  1, 0, f(3),          32'h0,         1);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0,          1, 0, 0,  1, 1, 32'h0,         32'h0,         0);

        // Clock/reset
        t = vecs[0];
        t.v = 0; t.u1 = 0; t.u2 = 0; t.wr = 0; t.wbe = 0; t.ordy = 1; t.fl = 0; t.rst = 1;
        drive(t);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #3;
        check("reset_out_valid", W'(out_valid), W'(1'b0));
        check("reset_bundle", actual_bundle(), W'(0));
        check("reset_in_ready", W'(in_ready), W'(1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #3;
            t = vecs[i];
            check($sformatf("v%0d_in_ready", i), W'(in_ready), W'(t.rdy));
            check($sformatf("v%0d_out_valid", i), W'(out_valid), W'(t.ov));
            check($sformatf("v%0d_read_addrs", i), W'({read_addr1, read_addr2}), W'({t.rs1, t.rs2}));
            if (t.cz) check($sformatf("v%0d_reset_bundle", i), actual_bundle(), W'(0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d_unexpected_out", i), W'(out_valid), W'(1'b0));
                end else begin
                    check($sformatf("v%0d_out_bundle", i), actual_bundle(), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (t.v && t.rdy) begin
                b.rs1_data = t.e1; b.rs2_data = t.e2; b.rd = t.rd; b.writes_rd = t.wr;
                exp_q.push_back(b);
            end
            if (t.fl || t.rst) exp_q.delete();
        end

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
